// File: rtl/fighter_pkg.sv
// fighter_pkg: action codes and arm-state type shared by both fighters and the game controller
package fighter_pkg;
  localparam logic [2:0] A_KICK   = 3'b000;
  localparam logic [2:0] A_PUNCH  = 3'b001;
  localparam logic [2:0] A_WAIT   = 3'b010;
  localparam logic [2:0] A_JUMP   = 3'b011;
  localparam logic [2:0] A_LEFT1  = 3'b100;
  localparam logic [2:0] A_LEFT2  = 3'b101;
  localparam logic [2:0] A_RIGHT1 = 3'b110;
  localparam logic [2:0] A_RIGHT2 = 3'b111;
  typedef enum logic {ARM_READY, ARM_SPENT} arm_t;
endpackage

// File: rtl/fighter_player_core_if.sv
// fighter_player_core_if: action strobe in, player state out
interface fighter_player_core_if #(parameter int N_POS = 3, parameter int PW = 2, parameter int HW = 2);
  logic             game_over;
  logic             action_en;
  logic [2:0]       own_action;
  logic [2:0]       opp_action;
  logic [PW-1:0]    opp_pos;
  logic [PW-1:0]    pos;
  logic [N_POS-1:0] pos_onehot;
  logic [HW-1:0]    health;
  logic             dead;
  logic             accepted;
  logic             hit;
  modport master (output game_over, action_en, own_action, opp_action, opp_pos,
                  input pos, pos_onehot, health, dead, accepted, hit);
  modport slave  (input game_over, action_en, own_action, opp_action, opp_pos,
                  output pos, pos_onehot, health, dead, accepted, hit);
endinterface

// File: rtl/fighter_move_clamp.sv
// fighter_move_clamp: next cell for a move or knockback, kept inside the arena and off the opponent
module fighter_move_clamp
  import fighter_pkg::*;
#(
  parameter int N_POS = 3,
  parameter int PW    = 2
) (
  input  logic [PW-1:0] pos,
  input  logic [PW-1:0] opp_pos,
  input  logic [2:0]    own_action,
  input  logic          knockback,
  output logic [PW-1:0] next_pos
);
  localparam logic signed [PW+1:0] ONE  = (PW+2)'(1);
  localparam logic signed [PW+1:0] TWO  = (PW+2)'(2);
  localparam logic signed [PW+1:0] MAXP = (PW+2)'(N_POS-1);
  logic signed [PW+1:0] p, o, step, t, c;
  logic move, right;
  always_comb begin
    p     = $signed({2'b00, pos});
    o     = $signed({2'b00, opp_pos});
    move  = own_action[2] && !knockback;
    // knockback always pushes away from the opponent
    right = knockback ? (p > o) : own_action[1];
    step  = knockback ? ONE : !move ? '0 : own_action[0] ? TWO : ONE;
    t     = right ? p + step : p - step;
    c     = t[PW+1] ? '0 : (t > MAXP) ? MAXP : t;
    c     = (move && right && p < o && c >= o) ? o - ONE :
            (move && !right && p > o && c <= o) ? o + ONE : c;
    next_pos = PW'(c);
  end
endmodule

// File: rtl/fighter_player_core.sv
// fighter_player_core: one player's position, health, regen and damage resolution per action strobe
module fighter_player_core
  import fighter_pkg::*;
#(
  parameter int SIDE        = 0,
  parameter int N_POS       = 3,
  parameter int PW          = 2,
  parameter int HW          = 2,
  parameter int KICK_RANGE  = 2,
  parameter int PUNCH_RANGE = 1,
  parameter int KICK_DMG    = 1,
  parameter int PUNCH_DMG   = 2,
  parameter int WAIT_REGEN  = 2
) (
  input logic clk,
  input logic reset,
  fighter_player_core_if.slave io
);
  localparam int WW = $clog2(WAIT_REGEN + 1);
  localparam logic [PW-1:0] POS0 = (SIDE != 0) ? PW'(N_POS - 1) : '0;
  arm_t                 arm;
  logic [PW-1:0]        pos, next_pos;
  logic [HW-1:0]        health, next_health;
  logic [WW-1:0]        wait_cnt, next_wc;
  logic [WW:0]          wc_inc;
  logic signed [PW+1:0] diff;
  logic [PW+1:0]        d;
  logic [HW+1:0]        hx, dmg;
  logic accepted, hit, acc, dead, knockback, kick_hit, punch_hit, waiting, regen;

  fighter_move_clamp #(.N_POS(N_POS), .PW(PW)) u_clamp (
    .pos(pos), .opp_pos(io.opp_pos), .own_action(io.own_action),
    .knockback(knockback), .next_pos(next_pos)
  );

  always_comb begin
    diff      = $signed({2'b00, pos}) - $signed({2'b00, io.opp_pos});
    d         = diff[PW+1] ? -diff : diff;
    knockback = io.own_action == A_KICK && io.opp_action == A_KICK && d == (PW+2)'(1);
    // a knockback exchange replaces the mutual kick damage
    kick_hit  = !knockback && io.opp_action == A_KICK && d <= (PW+2)'(KICK_RANGE) && io.own_action != A_JUMP;
    punch_hit = io.opp_action == A_PUNCH && d <= (PW+2)'(PUNCH_RANGE) && io.own_action != A_PUNCH;
    dmg       = kick_hit ? (HW+2)'(KICK_DMG) : punch_hit ? (HW+2)'(PUNCH_DMG) : '0;
    hx        = {2'b00, health};
    waiting   = io.own_action == A_WAIT && dmg == '0;
    wc_inc    = {1'b0, wait_cnt} + 1'b1;
    regen     = waiting && wc_inc == (WW+1)'(WAIT_REGEN);
    next_wc   = (waiting && !regen) ? WW'(wc_inc) : '0;
    next_health = (dmg != '0) ? ((dmg > hx) ? '0 : HW'(hx - dmg)) :
                  (regen && !(&health)) ? health + 1'b1 : health;
    dead      = health == '0;
    acc       = io.action_en && arm == ARM_READY && !io.game_over && !dead;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm      <= ARM_READY;
      pos      <= POS0;
      health   <= '1;
      wait_cnt <= '0;
      accepted <= 1'b0;
      hit      <= 1'b0;
    end else begin
      arm      <= !io.action_en ? ARM_READY : acc ? ARM_SPENT : arm;
      accepted <= acc;
      hit      <= acc && dmg != '0;
      if (acc) begin
        pos      <= next_pos;
        health   <= next_health;
        wait_cnt <= next_wc;
      end
    end
  end

  assign io.pos        = pos;
  assign io.pos_onehot = (N_POS)'(1) << pos;
  assign io.health     = health;
  assign io.dead       = dead;
  assign io.accepted   = accepted;
  assign io.hit        = hit;
endmodule
